// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic pipeline: operation encodings and the
// default operand width.
package arith_pkg;

  localparam int N_DEFAULT = 10;

  typedef enum logic [1:0] {
    MODE_SUM  = 2'b00,
    MODE_MUL  = 2'b01,
    MODE_SQR  = 2'b10,
    MODE_ZERO = 2'b11
  } mode_t;

endpackage

// File: rtl/arith_pipe_stage.sv
// One pipeline register: valid bit plus payload, with hold (stall) and flush.
// Payload only loads on a valid entry so the downstream view stays put across bubbles.
module arith_pipe_stage #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          hold,
  input  logic          valid_d,
  input  logic [DW-1:0] data_d,
  output logic          valid_q,
  output logic [DW-1:0] data_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (flush) begin
      // flush drops entries but leaves payload untouched
      valid_q <= 1'b0;
    end else if (!hold) begin
      valid_q <= valid_d;
      if (valid_d) data_q <= data_d;
    end
  end

endmodule

// File: rtl/arith_pipeline.sv
// Three-stage arithmetic pipeline: S1 pre-adds, S2 applies the mode operation,
// S3 presents the result with a valid/ready handshake and global stall.
module arith_pipeline
  import arith_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int W = 2 * N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [N-1:0] C,
  input  logic [N-1:0] D,
  input  logic [1:0]   mode,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] F,
  output logic         out_valid,
  input  logic         out_ready,
  input  logic         flush,
  output logic [1:0]   occupancy
);

  localparam int XW  = N + 1;
  localparam int S1W = 2 + N + 2 * XW;

  logic          stall;
  logic [XW-1:0] x1_d, x2_d;
  logic [S1W-1:0] s1_d, s1_q;
  logic          s1_valid, s2_valid, s3_valid;
  logic [XW-1:0] x1_q, x2_q;
  logic [N-1:0]  d_q;
  logic [1:0]    mode_q;
  logic [W-1:0]  x1_w, x2_w, d_w, s2_d, s2_q, s3_q;

  assign stall    = s3_valid && !out_ready;
  assign in_ready = !stall;

  assign x1_d = {1'b0, A} + {1'b0, B};
  assign x2_d = {1'b0, C} - {1'b0, D};
  assign s1_d = {mode, D, x2_d, x1_d};

  arith_pipe_stage #(.DW(S1W)) u_s1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .hold(stall),
    .valid_d(in_valid), .data_d(s1_d),
    .valid_q(s1_valid), .data_q(s1_q)
  );

  assign x1_q   = s1_q[XW-1:0];
  assign x2_q   = s1_q[2*XW-1:XW];
  assign d_q    = s1_q[2*XW+N-1:2*XW];
  assign mode_q = s1_q[S1W-1:S1W-2];

  assign x1_w = {{(W-XW){1'b0}}, x1_q};
  assign x2_w = {{(W-XW){x2_q[XW-1]}}, x2_q};
  assign d_w  = {{(W-N){1'b0}}, d_q};

  // all products truncate to W bits, giving the mod 2^W wrap
  always_comb begin
    s2_d = '0;
    case (mode_t'(mode_q))
      MODE_SUM:  s2_d = x1_w + x2_w;
      MODE_MUL:  s2_d = x1_w * x2_w;
      MODE_SQR:  s2_d = d_w * d_w;
      MODE_ZERO: s2_d = '0;
      default:   s2_d = '0;
    endcase
  end

  arith_pipe_stage #(.DW(W)) u_s2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .hold(stall),
    .valid_d(s1_valid), .data_d(s2_d),
    .valid_q(s2_valid), .data_q(s2_q)
  );

  arith_pipe_stage #(.DW(W)) u_s3 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .hold(stall),
    .valid_d(s2_valid), .data_d(s2_q),
    .valid_q(s3_valid), .data_q(s3_q)
  );

  assign F         = s3_q;
  assign out_valid = s3_valid;
  assign occupancy = {1'b0, s1_valid} + {1'b0, s2_valid} + {1'b0, s3_valid};

endmodule

// File: tb/tb_arith_pipeline.sv
// Self-checking bench for arith_pipeline (N=10): directed cases plus randomized
// traffic scored against an in-order queue of arithmetically computed results.
module tb_arith_pipeline;

  localparam int N = 10;
  localparam int W = 2 * N;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] A, B, C, D;
  logic [1:0]   mode;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] F;
  logic         out_valid;
  logic         out_ready;
  logic         flush;
  logic [1:0]   occupancy;

  int n_chk;
  int n_fail;
  longint exp_q[$];

  arith_pipeline #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .A(A), .B(B), .C(C), .D(D), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready),
    .F(F), .out_valid(out_valid), .out_ready(out_ready),
    .flush(flush), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint ref_f(input int a, input int b, input int c, input int d, input int m);
    longint x1, x2, r;
    x1 = a + b;
    x2 = c - d;
    case (m)
      0:       r = x1 + x2;
      1:       r = x1 * x2;
      2:       r = longint'(d) * d;
      default: r = 0;
    endcase
    return r & ((64'd1 << W) - 1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int a, input int b, input int c, input int d, input int m);
    A = N'(a); B = N'(b); C = N'(c); D = N'(d); mode = 2'(m);
    in_valid = 1'b1;
  endtask

  longint r0, r1, r2, prev_f;
  logic   prev_stall, prev_flush, stall_exp;

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; A = '0; B = '0; C = '0; D = '0; mode = '0;
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    #12;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_occ", occupancy, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_f", F, 0);
    rst_n = 1'b1;
    #2;

    // single sum, latency
    drive(10, 12, 6, 1, 0);
    step(); in_valid = 1'b0;
    check_eq("lat_e1_valid", out_valid, 0);
    step();
    check_eq("lat_e2_valid", out_valid, 0);
    step();
    check_eq("lat_e3_valid", out_valid, 1);
    check_eq("sum_f", F, 27);
    step();
    check_eq("lat_e4_valid", out_valid, 0);
    check_eq("bubble_f_hold", F, 27);

    // back-to-back mul then square
    drive(10, 12, 6, 1, 1);
    step();
    drive(30, 11, 9, 24, 2);
    step(); in_valid = 1'b0;
    step();
    check_eq("b2b_valid0", out_valid, 1);
    check_eq("b2b_mul", F, 110);
    step();
    check_eq("b2b_valid1", out_valid, 1);
    check_eq("b2b_sqr", F, 576);
    step();

    // negative x2 wraps
    drive(1, 1, 0, 1, 1);
    step(); in_valid = 1'b0;
    step(); step();
    check_eq("wrap_mul", F, 1048574);
    step(); step();

    // stall with three entries, then drain
    out_ready = 1'b0;
    r0 = ref_f(10, 12, 6, 1, 0);
    r1 = ref_f(10, 12, 6, 1, 1);
    r2 = ref_f(30, 11, 9, 24, 2);
    drive(10, 12, 6, 1, 0); step();
    drive(10, 12, 6, 1, 1); step();
    drive(30, 11, 9, 24, 2); step();
    in_valid = 1'b0;
    #1;
    check_eq("stall_in_ready", in_ready, 0);
    check_eq("stall_occ", occupancy, 3);
    check_eq("stall_f0", F, r0);
    step(); step();
    check_eq("stall_f_hold", F, r0);
    check_eq("stall_occ_hold", occupancy, 3);
    out_ready = 1'b1;
    #1;
    check_eq("drain_in_ready", in_ready, 1);
    step();
    check_eq("drain_f1", F, r1);
    check_eq("drain_occ1", occupancy, 2);
    step();
    check_eq("drain_f2", F, r2);
    check_eq("drain_occ2", occupancy, 1);
    step();
    check_eq("drain_done_valid", out_valid, 0);
    check_eq("drain_done_occ", occupancy, 0);

    // flush with two in flight; input offered during flush is dropped
    drive(3, 4, 5, 6, 0); step();
    drive(7, 8, 9, 1, 1); step();
    check_eq("pre_flush_occ", occupancy, 2);
    drive(2, 2, 2, 2, 2);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check_eq("flush_occ", occupancy, 0);
    check_eq("flush_valid", out_valid, 0);
    drive(100, 200, 50, 60, 1);
    step(); in_valid = 1'b0;
    step();
    check_eq("post_flush_e2", out_valid, 0);
    step();
    check_eq("post_flush_valid", out_valid, 1);
    check_eq("post_flush_f", F, ref_f(100, 200, 50, 60, 1));
    step();

    // asynchronous reset with a full stalled pipe
    out_ready = 1'b0;
    drive(500, 600, 700, 800, 0); step();
    drive(5, 6, 7, 8, 1); step();
    drive(9, 9, 9, 9, 2); step();
    in_valid = 1'b0;
    check_eq("pre_rst_occ", occupancy, 3);
    #3 rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid", out_valid, 0);
    check_eq("async_rst_f", F, 0);
    check_eq("async_rst_occ", occupancy, 0);
    check_eq("async_rst_in_ready", in_ready, 1);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1000, 1023, 3, 1000, 1);
    step(); in_valid = 1'b0;
    step();
    check_eq("post_rst_e2", out_valid, 0);
    step();
    check_eq("post_rst_valid", out_valid, 1);
    check_eq("post_rst_f", F, ref_f(1000, 1023, 3, 1000, 1));
    step();

    // randomized traffic against in-order scoreboard
    exp_q.delete();
    prev_stall = 1'b0; prev_flush = 1'b0; prev_f = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      A = N'($urandom_range(0, 1023));
      B = N'($urandom_range(0, 1023));
      C = N'($urandom_range(0, 1023));
      D = N'($urandom_range(0, 1023));
      mode = 2'($urandom_range(0, 3));
      in_valid  = ($urandom_range(0, 9) < 6);
      out_ready = (cyc > 580) || ($urandom_range(0, 9) < 6);
      flush     = (cyc < 560) && ($urandom_range(0, 39) == 0);
      #1;
      stall_exp = out_valid && !out_ready;
      check_eq("rnd_in_ready", in_ready, !stall_exp);
      check_eq("rnd_occ", occupancy, exp_q.size());
      if (prev_stall && !prev_flush) check_eq("rnd_f_hold", F, prev_f);
      if (flush) begin
        exp_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) check_eq("rnd_spurious_out", out_valid, 0);
          else check_eq("rnd_f", F, exp_q.pop_front());
        end
        if (in_valid && in_ready)
          exp_q.push_back(ref_f(int'(A), int'(B), int'(C), int'(D), int'(mode)));
      end
      prev_stall = stall_exp;
      prev_flush = flush;
      prev_f     = F;
      step();
    end
    in_valid = 1'b0; flush = 1'b0;
    #1;
    check_eq("rnd_final_occ", occupancy, exp_q.size());

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
